pfc_flow_ctrl: RTL

- Program-flow controller that sequences the program counter each cycle.
- Drives the PC next-address select (hold / increment / zero / target / loopback / ISE / stack) and the PC adder operand select.
- Resolves competing flow events: stall, replay, jump/call/return with delay slots, interrupt entry, hardware-loop loopback.
- Sits between the instruction decoder, interrupt logic, loop controller and return-address stack on one side, and the program counter on the other.

---
 rtl/pfc_flow_ctrl_pkg.sv | 37 +++
 rtl/pfc_flow_ctrl.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/pfc_flow_ctrl_pkg.sv
// Program-flow controller shared definitions.
// Holds the PC next-address select codes (shared with the program counter),
// the PC adder operand codes, the controller state encoding and the
// delay-slot redirect kind.
package pfc_flow_ctrl_pkg;

  // PC next-address select codes, consumed by the PC mux in the same cycle
  localparam logic [2:0] PC_SEL_HOLD   = 3'b000;
  localparam logic [2:0] PC_SEL_ADD    = 3'b001;
  localparam logic [2:0] PC_SEL_ZERO   = 3'b010;
  localparam logic [2:0] PC_SEL_TARGET = 3'b011;
  localparam logic [2:0] PC_SEL_LOOP   = 3'b100;
  localparam logic [2:0] PC_SEL_ISE    = 3'b101;
  localparam logic [2:0] PC_SEL_STACK  = 3'b110;

  // PC adder operand select
  localparam logic OPA_INC = 1'b0;
  localparam logic OPA_DEC = 1'b1;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'b00,
    ST_RUN   = 2'b01,
    ST_DELAY = 2'b10
  } pfc_state_e;

  // Where the PC goes once the delay slots have drained
  typedef enum logic {
    KIND_TGT = 1'b0,
    KIND_STK = 1'b1
  } pfc_kind_e;

  // True when more than one of the flow decodes is set at once
  function automatic logic multi_flow(input logic jump, input logic call, input logic ret);
    return (jump & call) | (jump & ret) | (call & ret);
  endfunction

endpackage

// File: rtl/pfc_flow_ctrl.sv
// Program-flow controller: picks the PC next-address source every cycle and
// resolves stall, replay, jump/call/return (with delay slots), interrupt entry
// and hardware-loop loopback.
//
// Ports:
//   clk_i                clock
//   reset_i              asynchronous active-low reset
//   stall_i              pipeline stall, PC holds
//   redo_i               replay previous instruction (PC-1)
//   jump_i/call_i/ret_i  decoded flow instruction
//   taken_i              condition for the flow instruction
//   ds_i                 delay-slot count of the flow instruction
//   loop_end_i           loop controller requests loopback
//   irq_i                level interrupt request
//   pfc_pc_sel_o         PC mux select
//   pfc_pcadd_opa_sel_o  PC adder operand (0 = +1, 1 = -1)
//   stack_push_o         push return address
//   stack_pop_o          pop return address
//   flush_o              squash the instruction currently fetched
//   irq_ack_o            interrupt accepted (pulse)
//   in_delay_o           delay slots in progress
//   illegal_o            illegal flow combination (pulse)
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_BOOT  | first cycle out of reset, PC forced to zero
// ST_RUN   | normal sequencing, all flow events arbitrated by priority
// ST_DELAY | draining delay slots; redirect to target/stack when cnt hits 1
module pfc_flow_ctrl
  import pfc_flow_ctrl_pkg::*;
#(
  parameter int DS_W = 2
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            stall_i,
  input  logic            redo_i,
  input  logic            jump_i,
  input  logic            call_i,
  input  logic            ret_i,
  input  logic            taken_i,
  input  logic [DS_W-1:0] ds_i,
  input  logic            loop_end_i,
  input  logic            irq_i,
  output logic [2:0]      pfc_pc_sel_o,
  output logic            pfc_pcadd_opa_sel_o,
  output logic            stack_push_o,
  output logic            stack_pop_o,
  output logic            flush_o,
  output logic            irq_ack_o,
  output logic            in_delay_o,
  output logic            illegal_o
);

  pfc_state_e      state_q, state_d;
  pfc_kind_e       kind_q, kind_d;
  logic [DS_W-1:0] cnt_q, cnt_d;

  logic flow_any;
  logic flow_multi;

  assign flow_any   = jump_i | call_i | ret_i;
  assign flow_multi = multi_flow(jump_i, call_i, ret_i);

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= ST_BOOT;
      cnt_q   <= '0;
      kind_q  <= KIND_TGT;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      kind_q  <= kind_d;
    end
  end

  always_comb begin
    state_d             = state_q;
    cnt_d               = cnt_q;
    kind_d              = kind_q;
    pfc_pc_sel_o        = PC_SEL_ADD;
    pfc_pcadd_opa_sel_o = OPA_INC;
    stack_push_o        = 1'b0;
    stack_pop_o         = 1'b0;
    flush_o             = 1'b0;
    irq_ack_o           = 1'b0;
    in_delay_o          = 1'b0;
    illegal_o           = 1'b0;

    case (state_q)
      ST_BOOT: begin
        pfc_pc_sel_o = PC_SEL_ZERO;
        state_d      = ST_RUN;
      end

      ST_RUN: begin
        if (stall_i) begin
          pfc_pc_sel_o = PC_SEL_HOLD;
        end else if (flow_multi) begin
          illegal_o = 1'b1;
        end else if (redo_i) begin
          pfc_pcadd_opa_sel_o = OPA_DEC;
        end else if (flow_any && taken_i) begin
          if (ds_i == '0) begin
            flush_o = 1'b1;
            if (ret_i) begin
              pfc_pc_sel_o = PC_SEL_STACK;
              stack_pop_o  = 1'b1;
            end else begin
              pfc_pc_sel_o = PC_SEL_TARGET;
              stack_push_o = call_i;
            end
          end else begin
            // The stack derives the post-delay-slot return address itself,
            // so the push can happen now rather than at the redirect.
            stack_push_o = call_i;
            cnt_d        = ds_i;
            kind_d       = ret_i ? KIND_STK : KIND_TGT;
            state_d      = ST_DELAY;
          end
        end else if (flow_any) begin
          // untaken flow instruction falls through as a plain increment
        end else if (irq_i) begin
          pfc_pc_sel_o = PC_SEL_ISE;
          stack_push_o = 1'b1;
          flush_o      = 1'b1;
          irq_ack_o    = 1'b1;
        end else if (loop_end_i) begin
          pfc_pc_sel_o = PC_SEL_LOOP;
        end
      end

      ST_DELAY: begin
        // redo, irq and loop_end are deliberately ignored here; irq is
        // level-sensitive and is picked up in the first RUN cycle.
        in_delay_o = 1'b1;
        if (stall_i) begin
          pfc_pc_sel_o = PC_SEL_HOLD;
        end else begin
          illegal_o = flow_any;
          if (cnt_q <= DS_W'(1)) begin
            if (kind_q == KIND_STK) begin
              pfc_pc_sel_o = PC_SEL_STACK;
              stack_pop_o  = 1'b1;
            end else begin
              pfc_pc_sel_o = PC_SEL_TARGET;
            end
            cnt_d   = '0;
            state_d = ST_RUN;
          end else begin
            cnt_d = cnt_q - DS_W'(1);
          end
        end
      end

      default: begin
        pfc_pc_sel_o = PC_SEL_ZERO;
        state_d      = ST_BOOT;
      end
    endcase
  end

endmodule
